usb_word_bridge: RTL and testbench
==================================

Name: usb_word_bridge

Overview:
- Parametrised byte-to-word bridge between the USB byte interface and the datapath.
- RX: packs incoming USB bytes into WORD_BYTES-wide words and buffers them in a FIFO for the datapath (stock data).
- TX: accepts datapath words (average data) and serialises them into bytes under a byte-level ack handshake.
- Successor to the fixed 32-bit USB top block; adds configurable word width, FIFO depth and byte order.

Parameters:
- WORD_BYTES, 4: bytes per word; W = 8*WORD_BYTES. Legal values ≥2.
- FIFO_DEPTH, 4: RX word FIFO entries. Power of 2, ≥2.
- MSB_FIRST, 1: 1 = first byte on the wire is the most-significant byte; 0 = least-significant byte first. Applies to both RX and TX.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- rx_byte  in  8  incoming USB byte.
- rx_strobe  in  1  rx_byte valid for one cycle.
- rx_clear  in  1  discards the partial word and clears rx_overflow.
- rx_word  out  W  FIFO head word.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- rx_overflow  out  1  sticky flag: a completed word was dropped.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- tx_word  in  W  word to transmit.
- tx_valid  in  1  tx_word offered.
- tx_ready  out  1  bridge idle and able to accept tx_word.
- tx_byte  out  8  current outgoing byte.
- tx_byte_valid  out  1  tx_byte valid.
- tx_byte_ack  in  1  USB side consumed tx_byte.

Behaviour:
- Reset (clock edge with n_rst=0): byte counter=0, FIFO empty, rx_valid=0, rx_word=0, rx_overflow=0, rx_count=0, TX state=IDLE, tx_ready=1, tx_byte=0, tx_byte_valid=0.
- RX assembly:
  - Each rx_strobe shifts rx_byte into a W-bit shift register and increments a byte counter (0..WORD_BYTES-1).
  - MSB_FIRST=1: shift left, new byte enters at [7:0]. MSB_FIRST=0: shift right, new byte enters at [W-1:W-8].
  - The strobe that delivers the last byte completes the word: the word is written to the FIFO at that clock edge and the counter wraps to 0. rx_valid rises the next cycle, so the latency from last strobe to rx_valid is 1 cycle.
- FIFO push/pop:
  - Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle (simultaneous push+pop leaves occupancy unchanged).
  - Pop whenever rx_valid && rx_ready. rx_word is the head entry; it must be stable while rx_valid=1 and no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH. rx_count is exact at every cycle.
- Overflow: a completed word arriving while the FIFO is full with no pop is dropped. rx_overflow is set the next cycle, the counter still wraps, and FIFO contents are unchanged.
- rx_clear (priority over rx_strobe in the same cycle):
  - Counter returns to 0, the partial word is discarded and rx_overflow is cleared.
  - FIFO contents are kept.
  - The rx_byte on the same cycle is ignored.
- TX FSM, IDLE:
  - tx_ready=1, tx_byte_valid=0.
  - On tx_valid: capture tx_word, set index=0 and go to SEND.
  - tx_byte_valid rises the cycle after acceptance.
- TX FSM, SEND:
  - tx_ready=0, tx_byte_valid=1.
  - tx_byte is byte[index] in wire order: MSB_FIRST=1 sends index 0 = word[W-1:W-8]; MSB_FIRST=0 sends index 0 = word[7:0].
  - On tx_byte_ack: index++. The ack on the last byte returns the FSM to IDLE, so tx_ready=1 the next cycle.
  - tx_byte must hold while unacked.
  - Minimum word period is WORD_BYTES+1 cycles, with ack tied high.
- tx_valid during SEND is ignored; the offering side holds its word until tx_ready.
- tx_byte_ack in IDLE is ignored.
- RX and TX paths are fully independent and may be active in the same cycle.
- Reset asserted mid-word or mid-send: every state returns to reset values on that edge; partial words and FIFO data are lost.

Test Plan:
- Defaults; strobe bytes 0x12,0x34,0x56,0x78 on consecutive cycles -> rx_valid=1 one cycle after the 4th strobe, rx_word=0x12345678, rx_count=1; rx_ready=1 -> empty next cycle.
- MSB_FIRST=0, same bytes -> rx_word=0x78563412. TX of 0xAABBCCDD -> bytes DD,CC,BB,AA.
- rx_ready=0; push 5 words 0x00000001..0x00000005 -> rx_count=4, rx_overflow=1; pops return 1..4. Repeat with full FIFO plus a pop coinciding with the 5th word's completion -> no overflow, 5 is present.
- Strobe 0xAA,0xBB; rx_clear; then 0x01,0x02,0x03,0x04 -> rx_word=0x01020304, rx_overflow=0.
- tx_word=0xDEADBEEF with tx_valid -> tx_byte DE,AD,BE,EF. Ack held low 3 cycles on byte 2 -> 0xAD held. tx_ready=1 the cycle after the final ack. A second tx_valid during SEND is not accepted.
- n_rst=0 after 2 RX bytes and mid-TX -> all outputs at reset values next edge; a full new 4-byte sequence then assembles correctly.

Source files
------------

// File: rtl/usb_word_bridge_if.sv
// Byte/word handshake bundle between the USB byte side, the bridge and the datapath.
// slave = bridge view, master = the surrounding USB/datapath logic view.
interface usb_word_bridge_if #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_byte;
  logic          rx_strobe;
  logic          rx_clear;
  logic [W-1:0]  rx_word;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_overflow;
  logic [CW-1:0] rx_count;
  logic [W-1:0]  tx_word;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_byte;
  logic          tx_byte_valid;
  logic          tx_byte_ack;

  modport slave (
    input  rx_byte, rx_strobe, rx_clear, rx_ready, tx_word, tx_valid, tx_byte_ack,
    output rx_word, rx_valid, rx_overflow, rx_count, tx_ready, tx_byte, tx_byte_valid
  );

  modport master (
    output rx_byte, rx_strobe, rx_clear, rx_ready, tx_word, tx_valid, tx_byte_ack,
    input  rx_word, rx_valid, rx_overflow, rx_count, tx_ready, tx_byte, tx_byte_valid
  );
endinterface

// File: rtl/usb_word_bridge.sv
// Packs USB bytes into words through an RX FIFO and serialises datapath words into bytes.
// RX: last strobe to rx_valid is 1 cycle; TX: one byte per ack, word period WORD_BYTES+1 cycles.
module usb_word_bridge #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic            clk,
  input logic            n_rst,
  usb_word_bridge_if.slave bus
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_BYTES);

  // ---------------- RX assembly and FIFO ----------------
  logic [W-1:0]  shift_q;
  logic [BW-1:0] byte_cnt_q;
  logic [W-1:0]  shifted;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          last_byte, word_done, full, push, pop, not_empty;

  always_comb begin
    shifted = MSB_FIRST ? {shift_q[W-9:0], bus.rx_byte} : {bus.rx_byte, shift_q[W-1:8]};
  end

  assign last_byte = (byte_cnt_q == BW'(WORD_BYTES - 1));
  assign word_done = bus.rx_strobe && !bus.rx_clear && last_byte;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = not_empty && bus.rx_ready;
  // A full FIFO can still take the new word when the head leaves in the same cycle.
  assign push      = word_done && (!full || pop);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.rx_clear) begin
        shift_q    <= '0;
        byte_cnt_q <= '0;
        overflow_q <= 1'b0;
      end else if (bus.rx_strobe) begin
        shift_q    <= shifted;
        byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BW'(1);
        if (word_done && !push) overflow_q <= 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= shifted;
  end

  assign bus.rx_valid    = not_empty;
  assign bus.rx_word     = not_empty ? mem[rd_ptr_q] : '0;
  assign bus.rx_overflow = overflow_q;
  assign bus.rx_count    = count_q;

  // ---------------- TX serialiser ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t     state_q, state_d;
  logic [W-1:0]  txw_q, txw_d;
  logic [BW-1:0] idx_q, idx_d;
  logic          tx_ready_c, tx_byte_valid_c;
  logic [7:0]    tx_byte_c;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= TX_IDLE;
      txw_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      txw_q   <= txw_d;
      idx_q   <= idx_d;
    end
  end

  // The held word is shifted on each ack so the wire byte always sits at a fixed end.
  always_comb begin
    state_d         = state_q;
    txw_d           = txw_q;
    idx_d           = idx_q;
    tx_ready_c      = 1'b0;
    tx_byte_valid_c = 1'b0;
    tx_byte_c       = 8'h00;
    case (state_q)
      TX_IDLE: begin
        tx_ready_c = 1'b1;
        if (bus.tx_valid) begin
          txw_d   = bus.tx_word;
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_byte_valid_c = 1'b1;
        tx_byte_c       = MSB_FIRST ? txw_q[W-1:W-8] : txw_q[7:0];
        if (bus.tx_byte_ack) begin
          txw_d = MSB_FIRST ? (txw_q << 8) : (txw_q >> 8);
          if (idx_q == BW'(WORD_BYTES - 1)) begin
            idx_d   = '0;
            state_d = TX_IDLE;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign bus.tx_ready      = tx_ready_c;
  assign bus.tx_byte_valid = tx_byte_valid_c;
  assign bus.tx_byte       = tx_byte_c;
endmodule

// File: tb/tb_usb_word_bridge.sv
// Drives an MSB-first and an LSB-first bridge with identical stimulus; scoreboards check each.
module tb_usb_word_bridge;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  rx_byte;
  logic        rx_strobe, rx_clear, rx_ready;
  logic [31:0] tx_word;
  logic        tx_valid, tx_byte_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_rx_m[$], q_rx_l[$];
  logic [7:0]  q_tx_m[$], q_tx_l[$];

  always #5 clk = ~clk;

  usb_word_bridge_if m_if ();
  usb_word_bridge_if l_if ();

  assign m_if.rx_byte = rx_byte;      assign l_if.rx_byte = rx_byte;
  assign m_if.rx_strobe = rx_strobe;  assign l_if.rx_strobe = rx_strobe;
  assign m_if.rx_clear = rx_clear;    assign l_if.rx_clear = rx_clear;
  assign m_if.rx_ready = rx_ready;    assign l_if.rx_ready = rx_ready;
  assign m_if.tx_word = tx_word;      assign l_if.tx_word = tx_word;
  assign m_if.tx_valid = tx_valid;    assign l_if.tx_valid = tx_valid;
  assign m_if.tx_byte_ack = tx_byte_ack; assign l_if.tx_byte_ack = tx_byte_ack;

  usb_word_bridge #(.WORD_BYTES(4), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .bus(m_if.slave));
  usb_word_bridge #(.WORD_BYTES(4), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .bus(l_if.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pop / acked byte is compared against the head of its queue.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (m_if.rx_valid && rx_ready) begin
        if (q_rx_m.size() == 0) check("rx_unexpected_msb", m_if.rx_word, 32'hxxxx_xxxx);
        else check("rx_word_msb", m_if.rx_word, q_rx_m.pop_front());
      end
      if (l_if.rx_valid && rx_ready) begin
        if (q_rx_l.size() == 0) check("rx_unexpected_lsb", l_if.rx_word, 32'hxxxx_xxxx);
        else check("rx_word_lsb", l_if.rx_word, q_rx_l.pop_front());
      end
      if (m_if.tx_byte_valid && tx_byte_ack) begin
        if (q_tx_m.size() == 0) check("tx_unexpected_msb", {24'h0, m_if.tx_byte}, 32'hxxxx_xxxx);
        else check("tx_byte_msb", {24'h0, m_if.tx_byte}, {24'h0, q_tx_m.pop_front()});
      end
      if (l_if.tx_byte_valid && tx_byte_ack) begin
        if (q_tx_l.size() == 0) check("tx_unexpected_lsb", {24'h0, l_if.tx_byte}, 32'hxxxx_xxxx);
        else check("tx_byte_lsb", {24'h0, l_if.tx_byte}, {24'h0, q_tx_l.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic strobe4(input logic [31:0] bytes_in_wire_order);
    for (int i = 3; i >= 0; i--) strobe(bytes_in_wire_order[8*i +: 8]);
  endtask

  task automatic exp_rx(input logic [31:0] wm, input logic [31:0] wl);
    q_rx_m.push_back(wm);
    q_rx_l.push_back(wl);
  endtask

  task automatic exp_tx(input logic [7:0] bm, input logic [7:0] bl);
    q_tx_m.push_back(bm);
    q_tx_l.push_back(bl);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_valid"}, {31'h0, m_if.rx_valid}, 32'h0);
    check({tag, "_rx_count"}, {29'h0, m_if.rx_count}, 32'h0);
    check({tag, "_rx_word"}, m_if.rx_word, 32'h0);
    check({tag, "_rx_overflow"}, {31'h0, m_if.rx_overflow}, 32'h0);
    check({tag, "_tx_ready"}, {31'h0, m_if.tx_ready}, 32'h1);
    check({tag, "_tx_byte_valid"}, {31'h0, m_if.tx_byte_valid}, 32'h0);
    check({tag, "_tx_byte"}, {24'h0, m_if.tx_byte}, 32'h0);
    check({tag, "_tx_ready_lsb"}, {31'h0, l_if.tx_ready}, 32'h1);
  endtask

  initial begin
    n_rst = 1'b0; rx_byte = 8'h00; rx_strobe = 1'b0; rx_clear = 1'b0; rx_ready = 1'b0;
    tx_word = 32'h0; tx_valid = 1'b0; tx_byte_ack = 1'b0;
    tick(); tick();
    check_reset_state("reset");
    n_rst = 1'b1;
    tick();

    // Basic assembly, both byte orders.
    exp_rx(32'h1234_5678, 32'h7856_3412);
    strobe4(32'h1234_5678);
    check("basic_rx_valid", {31'h0, m_if.rx_valid}, 32'h1);
    check("basic_rx_count", {29'h0, m_if.rx_count}, 32'h1);
    check("basic_rx_valid_lsb", {31'h0, l_if.rx_valid}, 32'h1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("basic_empty", {31'h0, m_if.rx_valid}, 32'h0);

    // Overflow: fifth word dropped with no pop.
    for (int n = 1; n <= 5; n++) begin
      if (n <= 4) exp_rx(32'(n), 32'(n) << 24);
      strobe4(32'(n));
    end
    check("ovf_count", {29'h0, m_if.rx_count}, 32'h4);
    check("ovf_flag", {31'h0, m_if.rx_overflow}, 32'h1);
    check("ovf_flag_lsb", {31'h0, l_if.rx_overflow}, 32'h1);
    rx_ready = 1'b1;
    repeat (4) tick();
    rx_ready = 1'b0;
    check("ovf_drained", {29'h0, m_if.rx_count}, 32'h0);
    check("ovf_sticky", {31'h0, m_if.rx_overflow}, 32'h1);
    rx_clear = 1'b1;
    tick();
    rx_clear = 1'b0;
    check("ovf_cleared", {31'h0, m_if.rx_overflow}, 32'h0);

    // Full FIFO with a pop coinciding with the fifth word's completion.
    for (int n = 1; n <= 5; n++) exp_rx(32'(n), 32'(n) << 24);
    for (int n = 1; n <= 4; n++) strobe4(32'(n));
    strobe(8'h00); strobe(8'h00); strobe(8'h00);
    rx_byte = 8'h05; rx_strobe = 1'b1; rx_ready = 1'b1;
    tick();
    rx_strobe = 1'b0;
    check("fullpop_count", {29'h0, m_if.rx_count}, 32'h4);
    check("fullpop_no_ovf", {31'h0, m_if.rx_overflow}, 32'h0);
    repeat (4) tick();
    rx_ready = 1'b0;
    check("fullpop_drained", {29'h0, m_if.rx_count}, 32'h0);

    // rx_clear discards the partial word and wins over a same-cycle strobe.
    strobe(8'hAA); strobe(8'hBB);
    rx_clear = 1'b1; rx_byte = 8'hEE; rx_strobe = 1'b1;
    tick();
    rx_clear = 1'b0; rx_strobe = 1'b0;
    check("clear_no_word", {29'h0, m_if.rx_count}, 32'h0);
    exp_rx(32'h0102_0304, 32'h0403_0201);
    strobe4(32'h0102_0304);
    check("clear_count", {29'h0, m_if.rx_count}, 32'h1);
    check("clear_ovf", {31'h0, m_if.rx_overflow}, 32'h0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;

    // TX with a stalled ack on the second byte and a competing offer during SEND.
    check("tx_idle_ready", {31'h0, m_if.tx_ready}, 32'h1);
    exp_tx(8'hDE, 8'hEF); exp_tx(8'hAD, 8'hBE); exp_tx(8'hBE, 8'hAD); exp_tx(8'hEF, 8'hDE);
    tx_word = 32'hDEAD_BEEF; tx_valid = 1'b1;
    tick();
    tx_word = 32'h1122_3344;
    check("tx_send_valid", {31'h0, m_if.tx_byte_valid}, 32'h1);
    check("tx_send_busy", {31'h0, m_if.tx_ready}, 32'h0);
    tx_byte_ack = 1'b1; tick(); tx_byte_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tx_hold_msb", {24'h0, m_if.tx_byte}, 32'hAD);
      check("tx_hold_lsb", {24'h0, l_if.tx_byte}, 32'hBE);
    end
    tx_valid = 1'b0;
    tx_byte_ack = 1'b1;
    repeat (2) tick();
    check("tx_not_done", {31'h0, m_if.tx_ready}, 32'h0);
    tick();
    tx_byte_ack = 1'b0;
    check("tx_done_ready", {31'h0, m_if.tx_ready}, 32'h1);
    check("tx_done_valid", {31'h0, m_if.tx_byte_valid}, 32'h0);

    // Back-to-back bytes with ack tied high; ack in IDLE afterwards is ignored.
    exp_tx(8'hAA, 8'hDD); exp_tx(8'hBB, 8'hCC); exp_tx(8'hCC, 8'hBB); exp_tx(8'hDD, 8'hAA);
    tx_word = 32'hAABB_CCDD; tx_valid = 1'b1; tx_byte_ack = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    check("tx2_ready", {31'h0, l_if.tx_ready}, 32'h1);
    tick();
    check("tx_idle_ack", {31'h0, m_if.tx_byte_valid}, 32'h0);
    tx_byte_ack = 1'b0;

    // Reset with a stored word, a partial word and a send in progress.
    strobe4(32'h9999_9999);
    strobe(8'h55); strobe(8'h66);
    exp_tx(8'hCA, 8'h0D);
    tx_word = 32'hCAFE_F00D; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_byte_ack = 1'b1;
    tick();
    tx_byte_ack = 1'b0;
    n_rst = 1'b0;
    tick();
    check_reset_state("midrst");
    n_rst = 1'b1;
    exp_rx(32'hA1B2_C3D4, 32'hD4C3_B2A1);
    strobe4(32'hA1B2_C3D4);
    check("post_rst_count", {29'h0, m_if.rx_count}, 32'h1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    repeat (3) tick();

    check("q_rx_msb_empty", q_rx_m.size(), 32'h0);
    check("q_rx_lsb_empty", q_rx_l.size(), 32'h0);
    check("q_tx_msb_empty", q_tx_m.size(), 32'h0);
    check("q_tx_lsb_empty", q_tx_l.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
